// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 write-only driver.
//   state_e        - controller FSM states
//   CMD_*          - HD44780 command bytes used by the driver
//   DEF_*          - default timing values in 50 MHz clocks
//   is_long_cmd()  - selects the long execution wait for clear/home
//   init_cmd()     - power-up initialisation command sequence
package lcd_pkg;

  localparam int unsigned CNT_W = 21;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;

  localparam int unsigned DEF_SETUP_CYC  = 2;
  localparam int unsigned DEF_EN_CYC     = 12;
  localparam int unsigned DEF_HOLD_CYC   = 10;
  localparam int unsigned DEF_SHORT_WAIT = 1850;
  localparam int unsigned DEF_LONG_WAIT  = 76000;
  localparam int unsigned DEF_PWRUP_WAIT = 2000000;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  localparam int unsigned INIT_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_PWRUP,
    ST_INIT
  } state_e;

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] c;
    unique case (idx)
      2'd0:    c = CMD_FUNC_SET;
      2'd1:    c = CMD_DISP_ON;
      2'd2:    c = CMD_CLEAR;
      default: c = CMD_ENTRY_MODE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_fifo.sv
// lcd_fifo: synchronous FIFO buffering {rs, data} entries for the driver.
//   clk_i, rst_ni   - clock, async active-low reset (empties the FIFO)
//   push_i, din_i   - write request and entry (ignored when full)
//   pop_i, dout_o   - read request and head entry (ignored when empty)
//   empty_o, full_o - occupancy flags
module lcd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/lcd_driver.sv
// lcd_driver: write-only HD44780 character LCD driver with a small write
// buffer. Each buffered byte is presented on lcd_data_o/lcd_rs_o, strobed
// with lcd_en_o, then followed by the command execution wait.
//   clk_i, rst_ni            - 50 MHz clock, async active-low reset
//   wr_valid_i/wr_ready_o    - byte handshake; wr_rs_i, wr_data_i payload
//   lcd_on_i                 - requested backlight/power state
//   busy_o                   - buffer non-empty, transfer or init active
//   lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o - panel pins
// Build option: define LCD_INIT_EN to run the power-up delay and the
// 0x38/0x0C/0x01/0x06 init sequence after reset before accepting bytes.
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned EN_CYC     = DEF_EN_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
  parameter int unsigned SHORT_WAIT = DEF_SHORT_WAIT,
  parameter int unsigned LONG_WAIT  = DEF_LONG_WAIT,
  parameter int unsigned PWRUP_WAIT = DEF_PWRUP_WAIT,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  input  logic       wr_rs_i,
  input  logic [7:0] wr_data_i,
  input  logic       lcd_on_i,
  output logic       busy_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(SHORT_WAIT - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(LONG_WAIT - 1);
  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(PWRUP_WAIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             on_q;
  logic             alive_q;   // low during reset and its first cycle out
  logic             init_done;

  logic       fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [8:0] fifo_dout;

`ifdef LCD_INIT_EN
  logic [2:0] init_idx_q, init_idx_d;
  logic       init_done_q, init_done_d;
  assign init_done = init_done_q;
`else
  assign init_done = 1'b1;
`endif

  lcd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .din_i   ({wr_rs_i, wr_data_i}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign fifo_push = wr_valid_i && wr_ready_o;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
`ifdef LCD_INIT_EN
      state_q     <= ST_PWRUP;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
`else
      state_q     <= ST_IDLE;
`endif
      cnt_q   <= LD_PWRUP;
      data_q  <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      on_q    <= 1'b0;
      alive_q <= 1'b0;
    end else begin
`ifdef LCD_INIT_EN
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
`endif
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      on_q    <= lcd_on_i;
      alive_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    rs_d     = rs_q;
    fifo_pop = 1'b0;
`ifdef LCD_INIT_EN
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
`endif
    unique case (state_q)
      ST_IDLE: ;
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = LD_EN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = is_long_cmd(rs_q, data_q) ? LD_LONG : LD_SHORT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
`ifdef LCD_INIT_EN
          // Init commands chain straight into SETUP, same as buffered bytes.
          if (!init_done_q) begin
            if (init_idx_q == 3'(INIT_LEN)) begin
              init_done_d = 1'b1;
            end else begin
              state_d    = ST_SETUP;
              cnt_d      = LD_SETUP;
              data_d     = init_cmd(init_idx_q[1:0]);
              rs_d       = 1'b0;
              init_idx_d = init_idx_q + 1'b1;
            end
          end
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef LCD_INIT_EN
      ST_PWRUP: begin
        if (cnt_q == '0) begin
          state_d = ST_INIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_INIT: begin
        state_d    = ST_SETUP;
        cnt_d      = LD_SETUP;
        data_d     = init_cmd(init_idx_q[1:0]);
        rs_d       = 1'b0;
        init_idx_d = init_idx_q + 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // IDLE and a finished WAIT share the pop path, so queued bytes run
    // back-to-back without passing through an idle cycle.
    if (state_d == ST_IDLE && !fifo_empty) begin
      fifo_pop          = 1'b1;
      state_d           = ST_SETUP;
      cnt_d             = LD_SETUP;
      {rs_d, data_d}    = fifo_dout;
    end
  end

  // Output logic
  always_comb begin
    en_d       = (state_d == ST_PULSE);
    busy_o     = alive_q && (!fifo_empty || (state_q != ST_IDLE));
    wr_ready_o = alive_q && init_done && !fifo_full;
  end

  assign lcd_data_o = data_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = en_q;
  assign lcd_on_o   = on_q;

endmodule
